// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the byte-enable helper used by the lane aligner.
package dmem_pkg;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] SZ_RSV = 2'd3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      SZ_B:    byte_en = 4'b0001 << ofs;
      SZ_H:    byte_en = 4'b0011 << ofs;
      SZ_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store byte enables and replicated data, load
// lane select with sign/zero extension, and the misalignment flag. Purely combinational.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  ofs,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    be        = byte_en(size, ofs);
    misalign  = ((size == SZ_H) && ofs[0]) || ((size == SZ_W) && (ofs != 2'd0));
    lane_b    = rword[{ofs, 3'b000} +: 8];
    lane_h    = ofs[1] ? rword[31:16] : rword[15:0];
    wdata_rep = wdata;
    rdata_ext = rword;
    case (size)
      SZ_B: begin
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
      end
      SZ_H: begin
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, response pulse WAIT_CYCLES+1
// cycles after acceptance; req_ready is low from acceptance until the response cycle ends.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDXW = $clog2(DEPTH_WORDS);

  state_t      state, next_state;
  logic [15:0] cnt, next_cnt;
  logic        cap;

  logic        l_we, l_uns;
  logic [31:0] l_addr, l_wdata;
  logic [1:0]  l_size;

  logic        a_we, a_uns;
  logic [31:0] a_addr, a_wdata;
  logic [1:0]  a_size;

  logic [31:0] mem [DEPTH_WORDS];
  logic [IDXW-1:0] idx;
  logic [31:0] rword, wdata_rep, rdata_ext, merged;
  logic [3:0]  be;
  logic        misalign, oor, err, entering;

  // With zero wait states the access happens on the acceptance edge itself,
  // so the request is taken straight from the ports while idle.
  always_comb begin
    a_we    = l_we;
    a_addr  = l_addr;
    a_wdata = l_wdata;
    a_size  = l_size;
    a_uns   = l_uns;
    if (state == IDLE) begin
      a_we    = req_we;
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_size  = req_size;
      a_uns   = req_unsigned;
    end
  end

  dmem_lane_align u_align (
    .ofs         (a_addr[1:0]),
    .size        (a_size),
    .is_unsigned (a_uns),
    .wdata       (a_wdata),
    .rword       (rword),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext),
    .misalign    (misalign)
  );

  assign idx      = a_addr[IDXW+1:2];
  assign rword    = mem[idx];
  assign oor      = {2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign err      = (a_size == SZ_RSV) || misalign || oor;
  assign entering = (next_state == RESP) && (state != RESP);

  always_comb begin
    merged = rword;
    for (int i = 0; i < 4; i++)
      if (be[i]) merged[8*i +: 8] = wdata_rep[8*i +: 8];
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    cap        = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          cap        = 1'b1;
          next_cnt   = 16'(WAIT_CYCLES);
          next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        next_cnt = cnt - 16'd1;
        if (cnt <= 16'd1) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      req_ready  <= (next_state == IDLE);
      resp_valid <= entering;
      resp_err   <= entering && err;
      resp_rdata <= (entering && !err && !a_we) ? rdata_ext : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      l_we    <= req_we;
      l_addr  <= req_addr;
      l_wdata <= req_wdata;
      l_size  <= req_size;
      l_uns   <= req_unsigned;
    end
  end

  // A reset landing on the RESP-entry edge must drop the store.
  always_ff @(posedge clk) begin
    if (rst && entering && a_we && !err)
      mem[idx] <= merged;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder against a byte-addressed reference model.
module tb_dmem_responder;

  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        v0, rdy0, we0, uns0, rv0, re0;
  logic [31:0] addr0, wdata0, rd0;
  logic [1:0]  size0;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0),
    .req_we(we0), .req_addr(addr0), .req_wdata(wdata0),
    .req_size(size0), .req_unsigned(uns0),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(re0)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mb [4096];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte array, access width 1<<size, natural alignment required.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       output logic err, output logic [31:0] rd);
    int nb;
    logic [31:0] v;
    nb  = 1 << size;
    err = (size == 2'd3) || ((addr % nb) != 0) || (addr >= 32'd4096);
    rd  = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) mb[addr + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[addr + i];
        if (nb < 4 && !uns && v[8*nb-1])
          for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        rd = v;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge where the response was seen.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic uns,
                      output logic [31:0] rd, output logic er, output int lat);
    int g;
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    g = 0;
    while (req_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; rd = 'x; er = 'x;
    for (int n = 1; n <= W + 4; n++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = n; rd = resp_rdata; er = resp_err;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     output logic [31:0] rd, output logic er);
    logic        e_err;
    logic [31:0] e_rd;
    int          lat;
    model(we, addr, wdata, size, uns, e_err, e_rd);
    xact(we, addr, wdata, size, uns, rd, er, lat);
    check({tag, " latency"}, 32'(lat), 32'(W + 1));
    check({tag, " err"}, {31'b0, er}, {31'b0, e_err});
    check({tag, " rdata"}, rd, e_rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, pre, ra, rw;
    logic        er, rwe, ru;
    logic [1:0]  rs;
    int          pulses;

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0;
    v0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; size0 = '0; uns0 = 1'b0;

    repeat (3) @(negedge clk);
    check("reset req_ready", {31'b0, req_ready}, 32'd0);
    check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset resp_err", {31'b0, resp_err}, 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset req_ready w0", {31'b0, rdy0}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ready after release", {31'b0, req_ready}, 32'd1);
    check("ready after release w0", {31'b0, rdy0}, 32'd1);

    // Zero wait states, valid held high: store once, then back-to-back loads.
    we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'hCAFEF00D; size0 = 2'd2; uns0 = 1'b0; v0 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("w0 ready/valid k=%0d", k), {30'b0, rdy0, rv0},
            (k % 2 == 0) ? 32'd2 : 32'd1);
      if (k % 2 == 1) begin
        check($sformatf("w0 rdata k=%0d", k), rd0, (k == 1) ? 32'd0 : 32'hCAFEF00D);
        check($sformatf("w0 err k=%0d", k), {31'b0, re0}, 32'd0);
      end
      if (k == 1) we0 = 1'b0;
    end
    v0 = 1'b0;
    @(negedge clk);

    run("t1 store", 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, rd, er);
    run("t1 load", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, er);
    check("t1 load value", rd, 32'hDEADBEEF);

    for (int i = 0; i < 64; i++)
      run("preload", 1'b1, 32'(4 * i), $urandom, 2'd2, 1'b0, rd, er);

    run("t2 word", 1'b1, 32'h10, 32'h11223344, 2'd2, 1'b0, rd, er);
    run("t2 sb", 1'b1, 32'h13, 32'h00000080, 2'd0, 1'b0, rd, er);
    run("t2 lw", 0, 32'h10, 32'h0, 2'd2, 1'b0, rd, er);
    check("t2 merged word", rd, 32'h80223344);
    run("t2 lb", 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, rd, er);
    check("t2 signed byte", rd, 32'hFFFFFF80);
    run("t2 lbu", 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, rd, er);
    check("t2 unsigned byte", rd, 32'h00000080);

    run("t3 sh", 1'b1, 32'h12, 32'h0000BEEF, 2'd1, 1'b0, rd, er);
    run("t3 lh", 1'b0, 32'h12, 32'h0, 2'd1, 1'b0, rd, er);
    check("t3 signed half", rd, 32'hFFFFBEEF);
    run("t3 lh mis", 1'b0, 32'h11, 32'h0, 2'd1, 1'b0, rd, er);
    check("t3 misaligned err", {31'b0, er}, 32'd1);
    run("t3 sh mis", 1'b1, 32'h11, 32'h0000AAAA, 2'd1, 1'b0, rd, er);
    run("t3 lw", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, er);
    check("t3 word unchanged", rd, 32'hBEEF3344);

    run("t4 oor", 1'b0, 32'h1000, 32'h0, 2'd2, 1'b0, rd, er);
    check("t4 out of range err", {31'b0, er}, 32'd1);
    run("t4 rsv", 1'b1, 32'h10, 32'hFFFFFFFF, 2'd3, 1'b0, rd, er);
    check("t4 reserved err", {31'b0, er}, 32'd1);
    run("t4 lw", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, er);
    check("t4 no write", rd, 32'hBEEF3344);
    run("t4 last st", 1'b1, 32'hFFC, 32'hA5A55A5A, 2'd2, 1'b0, rd, er);
    run("t4 last ld", 1'b0, 32'hFFC, 32'h0, 2'd2, 1'b0, rd, er);
    check("t4 last word", rd, 32'hA5A55A5A);
    run("t4 word mis", 1'b0, 32'h12, 32'h0, 2'd2, 1'b0, rd, er);

    for (int i = 0; i < 120; i++) begin
      ra  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 255));
      rw  = $urandom;
      rs  = 2'($urandom_range(0, 3));
      rwe = 1'($urandom_range(0, 1));
      ru  = 1'($urandom_range(0, 1));
      run($sformatf("rand %0d", i), rwe, ra, rw, rs, ru, rd, er);
    end

    // Reset in WAIT: the store is abandoned and no response appears.
    run("t6 pre", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, pre, er);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = 2'd2;
    req_unsigned = 1'b0; req_valid = 1'b1;
    for (int g = 0; g < 20 && req_ready !== 1'b1; g++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    @(negedge clk);
    if (resp_valid === 1'b1) pulses++;
    rst = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) pulses++;
    end
    check("t6 no response", 32'(pulses), 32'd0);
    run("t6 load", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, rd, er);
    check("t6 prior value", rd, pre);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the CPU data-memory port. It serves load and store requests from the pipeline's MEM stage over a valid/ready request channel and a one-cycle response pulse. Storage is an internal word-organised array with programmable wait states. It handles byte, half and word accesses in little-endian order, sign/zero-extends loads, and flags misaligned, out-of-range or reserved-size requests.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
WAIT_CYCLES, 2, extra cycles between request acceptance and response; 0 is legal.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-low.
req_valid  input  1  CPU presents a request.
req_ready  output  1  responder can accept a request this cycle.
req_we  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-aligned: byte in [7:0], half in [15:0].
req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = reserved.
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
resp_valid  output  1  one-cycle pulse that completes a request.
resp_rdata  output  32  load data, valid with resp_valid. It is 0 for stores and for errors.
resp_err  output  1  marks the request as faulted, valid with resp_valid.

Behaviour:
- Reset (rst=0 sampled on a clk edge):
  - state goes to IDLE.
  - req_ready, resp_valid, resp_rdata and resp_err are all 0.
  - Array contents are not cleared.
  - req_ready rises on the first edge after rst returns to 1.
- State machine: IDLE, WAIT, RESP. All outputs are registered.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch we/addr/wdata/size/unsigned and load the wait counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
  - req_ready drops to 0 on the acceptance edge.
- WAIT:
  - Counter decrements each cycle.
  - When it reaches 1, the next state is RESP.
  - Inputs are ignored; req_ready=0.
- Entering RESP:
  - Perform the array access using the latched request.
  - Set resp_valid=1 for exactly one cycle.
- RESP: always returns to IDLE; req_ready=1 again the following cycle.
- Timing:
  - Latency from acceptance edge to resp_valid high is WAIT_CYCLES+1 cycles.
  - Maximum throughput is one request per WAIT_CYCLES+2 cycles.
- Error conditions (checked in this order; any one sets resp_err=1, resp_rdata=0, no write):
  - req_size=3.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - addr[31:2] ≥ DEPTH_WORDS.
- Stores:
  - Byte enables: byte = 1<<addr[1:0]; half = 3<<addr[1:0]; word = 4'hF.
  - Data is replicated into all lanes; only enabled bytes are merged into the word.
- Loads:
  - Select the lane given by addr[1:0].
  - Extend to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- Reset during WAIT or RESP entry:
  - The transaction is aborted, no response is issued, and a pending store is discarded.
  - The write only happens on the WAIT/IDLE→RESP edge with rst=1.
- req_valid held high during WAIT/RESP is not a second request. It is accepted only in IDLE.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_RSV;
  - state typedef {IDLE, WAIT, RESP};
  - byte-enable function.
- One combinational sub-module, dmem_lane_align:
  - inputs: addr[1:0], size, unsigned, wdata, raw read word;
  - outputs: byte enables, lane-replicated store data, extended load data, misalign flag.

Test Plan:
1. Reset then word store 0xDEADBEEF @0x10, WAIT_CYCLES=2 -> req_ready 0 during reset, 1 one edge after release; resp_valid 3 cycles after acceptance, resp_err=0. A word load @0x10 then returns 0xDEADBEEF.
2. Byte store 0x80 @0x13 over 0x11223344 -> word becomes 0x80223344. Signed byte load @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080.
3. Half store 0xBEEF @0x12, then signed half load @0x12 -> 0xFFFFBEEF. Half load @0x11 -> resp_err=1, rdata=0, memory unchanged.
4. Word load @0x1000 with DEPTH_WORDS=1024 -> resp_err=1. req_size=3 -> resp_err=1, no write.
5. Build with WAIT_CYCLES=0 and keep req_valid high continuously -> acceptances every 2 cycles, resp_valid one cycle after each, req_ready low in RESP.
6. Store 0x12345678 @0x20 with rst pulled low during WAIT -> no resp_valid pulse. A later load @0x20 returns the prior value.
